// File: rtl/regfile_2r1w_pkg.sv
// regfile_2r1w_pkg: shared sizing constants for the register file
package regfile_2r1w_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int NREGS = 2 ** ADDR_W;
  localparam int REG_ZERO = 0;
endpackage

// File: rtl/regfile_entry.sv
// regfile_entry: one data register with load enable plus its pending flop
module regfile_entry import regfile_2r1w_pkg::*; #(
  parameter int DATA_W = regfile_2r1w_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ld,
  input  logic [DATA_W-1:0] i_d,
  input  logic              i_set,
  input  logic              i_clr,
  output logic [DATA_W-1:0] o_q,
  output logic              o_pend
);
  logic [DATA_W-1:0] r_q;
  logic              r_pend;
  // a reserve in the same cycle as writeback wins: a newer producer is in flight
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_q    <= '0;
      r_pend <= 1'b0;
    end else begin
      r_q    <= i_ld ? i_d : r_q;
      r_pend <= i_set ? 1'b1 : i_clr ? 1'b0 : r_pend;
    end
  assign o_q    = r_q;
  assign o_pend = r_pend;
endmodule

// File: rtl/regfile_2r1w.sv
// regfile_2r1w: 2-read/1-write register file with write-through bypass and RAW scoreboard
module regfile_2r1w import regfile_2r1w_pkg::*; #(
  parameter int DATA_W = regfile_2r1w_pkg::DATA_W,
  parameter int ADDR_W = regfile_2r1w_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  input  logic              rsv,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              busy_a,
  output logic              busy_b
);
  localparam int NR = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZR = ADDR_W'(REG_ZERO);
  logic [NR-1:0][DATA_W-1:0] w_mem;
  logic [NR-1:0]             w_pend;
  logic                      w_hit_a;
  logic                      w_hit_b;
  assign w_mem[0]  = '0;
  assign w_pend[0] = 1'b0;
  for (genvar g = 1; g < NR; g++) begin : g_ent
    regfile_entry #(.DATA_W(DATA_W)) u_ent (
      .clk   (clk),
      .rst   (rst),
      .i_ld  (we && waddr == ADDR_W'(g)),
      .i_d   (wdata),
      .i_set (rsv && rsv_addr == ADDR_W'(g)),
      .i_clr (we && waddr == ADDR_W'(g)),
      .o_q   (w_mem[g]),
      .o_pend(w_pend[g])
    );
  end
  // a same-cycle writeback both supplies the data and satisfies the hazard
  assign w_hit_a = we && waddr == raddr_a;
  assign w_hit_b = we && waddr == raddr_b;
  always_comb begin
    rdata_a = raddr_a == ZR ? '0 : w_hit_a ? wdata : w_mem[raddr_a];
    rdata_b = raddr_b == ZR ? '0 : w_hit_b ? wdata : w_mem[raddr_b];
    busy_a  = w_pend[raddr_a] && !w_hit_a;
    busy_b  = w_pend[raddr_b] && !w_hit_b;
  end
endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

Eight-entry, 16-bit general-purpose register file for the pipelined CPU. Decode reads it and writeback writes it.
- Two combinational read ports serve the decode stage; one synchronous write port serves writeback.
- A per-register pending (scoreboard) bit lets decode detect RAW hazards against instructions still in flight.
- Register 0 reads as zero, ignores writes and is never pending.

## Interface
Parameters:
- DATA_W, 16, register width
- ADDR_W, 3, register index width (NREGS = 2**ADDR_W = 8)

Ports (clock and reset fixed: one clock `clk`; reset `rst` is asynchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- we  in  1  writeback write enable
- waddr  in  ADDR_W  write index
- wdata  in  DATA_W  write data
- raddr_a  in  ADDR_W  read port A index
- raddr_b  in  ADDR_W  read port B index
- rdata_a  out  DATA_W  read port A data
- rdata_b  out  DATA_W  read port B data
- rsv  in  1  decode issues an instruction that will write rsv_addr
- rsv_addr  in  ADDR_W  destination being reserved
- busy_a  out  1  raddr_a has an outstanding producer
- busy_b  out  1  raddr_b has an outstanding producer

## Operation
- Storage:
  - mem[1..7] are DATA_W flops, each with a load enable.
  - mem[0] is a constant 0 and has no flops.
- Write: at a rising clk with we=1 and waddr≠0, mem[waddr] ← wdata. Writes with waddr=0 are dropped.
- Read, port X in {a, b}:
  - raddr_X=0 → 0.
  - Else if we=1 and waddr==raddr_X → wdata (write-through bypass, same cycle).
  - Else → mem[raddr_X].
  - Both ports are independent and may read the same index.
- Pending bits pend[1..7]:
  - rsv=1, rsv_addr≠0 → pend[rsv_addr] set at the edge.
  - we=1, waddr≠0 → pend[waddr] cleared at the edge.
  - Same index, both events in one cycle: set wins. A newer producer is issued, so the register stays pending.
  - rsv_addr=0 is ignored.
- busy_X = pend[raddr_X] AND NOT (we AND waddr==raddr_X). The bypass satisfies a consumer in the cycle its producer writes back.
- busy_X is 0 whenever raddr_X=0.
- Width: no arithmetic; wdata is stored unmodified; no truncation or extension.

## Timing
- Read latency: 0 cycles (combinational from raddr, we, waddr, wdata, mem).
- Write latency: 1 edge. A value written at edge N is visible from mem after edge N. Via the bypass it is already visible during the cycle before edge N.
- Reserve latency: 1 edge. busy rises the cycle after rsv.
- Reset, asserted at any time including mid-write:
  - All mem and pend clear immediately, with no clock needed.
  - While rst=1: rdata_a = rdata_b = 0 unless the bypass condition holds combinationally; busy_a = busy_b = 0.
  - Writes and reserves presented at an edge while rst=1 are discarded.
- Release: the first edge with rst=0 performs normal write/reserve.

## Structure
- Shared package holds DATA_W, ADDR_W, NREGS and the zero-register index constant REG_ZERO=0.
- Sub-module regfile_entry: one DATA_W register with load enable plus its pending flop, async active-high reset. Instantiate it 7 times (indices 1..7).
- Read muxes, bypass and busy logic live in the top module.

## Test plan
- Reset: assert rst mid-simulation after writing R3=0xBEEF → rdata for raddr=3 reads 0x0000 immediately, busy_a=0, before any clk edge.
- Write/read: we=1, waddr=5, wdata=0x1234 at edge; next cycle raddr_a=5, raddr_b=5 → both 0x1234; raddr_a=4 → 0x0000.
- Bypass: R2=0x0001 stored; in one cycle we=1, waddr=2, wdata=0xA5A5 and raddr_a=2 → rdata_a=0xA5A5 in that same cycle.
- Zero register: we=1, waddr=0, wdata=0xFFFF; rsv=1, rsv_addr=0 → raddr_a=0 reads 0x0000, busy_a=0 afterward.
- Scoreboard: rsv R6 at edge N → busy_b=1 (raddr_b=6) from N+1. Writeback we to R6 in cycle M → busy_b=0 in cycle M, and pend clears at edge M.
- Simultaneous: rsv R6 and we R6 in the same cycle → after the edge, mem[6]=wdata and busy for R6 stays 1.
